// File: rtl/regfile_writer.sv
// RV32 register file write side: 2-entry write-back FIFO draining into a 32x32 array.
// Define REGFILE_WB_BYPASS_EN to let read ports forward buffered (uncommitted) writes.
module regfile_writer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            hold,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            commit_valid,
  output logic [4:0]      commit_rd,
  output logic [1:0]      pending
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t         fifo [2];
  logic            head, tail;
  logic [1:0]      count;
  logic [XLEN-1:0] regs [32];
  logic            push, pop;

  assign wb_ready = !rst && (count < 2'(DEPTH));
  // x0 writes complete the handshake but never occupy a slot
  assign push     = wb_valid && wb_ready && (wb_rd != 5'd0);
  assign pop      = (count != 2'd0) && !hold && !rst;
  assign pending  = count;

  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{rd: wb_rd, data: wb_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      commit_valid <= 1'b0;
      commit_rd    <= 5'd0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      commit_valid <= pop;
      if (push) tail <= ~tail;
      if (pop) begin
        regs[fifo[head].rd] <= fifo[head].data;
        commit_rd           <= fifo[head].rd;
        head                <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  logic [4:0]      raddr [2];
  logic [XLEN-1:0] rdata [2];

  assign raddr[0] = rs1_addr;
  assign raddr[1] = rs2_addr;
  assign rs1_data = rdata[0];
  assign rs2_data = rdata[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
`ifdef REGFILE_WB_BYPASS_EN
      // older entry first so the youngest match overrides it
      if (count == 2'd2 && fifo[head].rd == raddr[p]) rdata[p] = fifo[head].data;
      if (count != 2'd0 && fifo[~tail].rd == raddr[p]) rdata[p] = fifo[~tail].data;
`endif
      if (rst || raddr[p] == 5'd0) rdata[p] = '0;
    end
  end

endmodule
